freq_divider_gen: RTL
=====================

Name: freq_divider_gen

Overview:
Parametrised programmable clock divider for the function-generator datapath. It is the successor to the fixed 4-entry frequency selector.
- Produces a 50%-duty divided output clock from either a power-of-two preset table or a user-supplied divisor.
- Switches frequency glitch-free, only at half-period boundaries.
- Adds enable, phase resync and a one-cycle toggle strobe.
- Provides an independent free-running auxiliary slow clock used for display/scan timing.

Parameters:
- CNT_W, 16, width of the half-period counter and divisor.
- SEL_W, 2, width of the preset frequency select; table has 2**SEL_W entries.
- BASE_DIV, 400, half-period in clk cycles for the fastest preset (freq = all ones).
- AUX_BIT, 11, aux_clk toggles every 2**AUX_BIT clk cycles.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  counter advance enable; aux prescaler ignores it.
- freq  in  SEL_W  preset select; larger code = higher frequency.
- div_mode  in  1  0 = preset table, 1 = div_custom.
- div_custom  in  CNT_W  custom half-period in clk cycles.
- sync_clr  in  1  synchronous phase restart.
- out_clk  out  1  divided clock, registered.
- out_tick  out  1  one-cycle pulse in the cycle out_clk toggles.
- aux_clk  out  1  free-running slow clock, registered.
- div_active  out  CNT_W  half-period currently in force, for debug/status.

Behaviour:
- Reset (async, rst=1):
  - cnt = 0, out_clk = 0, out_tick = 0, aux_clk = 0, aux prescaler = 0.
  - div_active = slowest preset, BASE_DIV << (2**SEL_W - 1), saturated.
- Requested divisor div_req, combinational:
  - div_mode=0: BASE_DIV << (2**SEL_W-1-freq).
  - If the shifted value exceeds 2**CNT_W-1, saturate to all ones.
  - div_mode=1: div_custom.
  - A value of 0 is treated as 1.
- Half-period counter, when en=1 and sync_clr=0:
  - If cnt == div_active-1: cnt <= 0, out_clk toggles, out_tick=1 in that same cycle, div_active <= div_req.
  - Otherwise cnt <= cnt+1 and out_tick=0.
- Resulting timing: each out_clk level lasts exactly div_active cycles. Period is 2*div_active. With div_active=1, out_clk = clk/2 and out_tick is high continuously.
- Frequency change: freq, div_mode or div_custom changes are sampled only at the boundary. A new divisor takes effect from the next half-period, so no runt pulses occur. Changes that revert before the boundary have no effect.
- en=0: cnt, out_clk and div_active hold; out_tick=0. Resuming continues the same half-period.
- sync_clr=1 has priority over en:
  - cnt <= 0, out_clk <= 0, out_tick <= 0, div_active <= div_req.
  - The next half-period starts the following cycle.
- Defensive wrap: if cnt >= div_active (cannot occur in normal operation), treat it as the boundary.
- Aux prescaler:
  - AUX_BIT-bit free-running counter. It counts regardless of en and sync_clr; only rst clears it.
  - When it wraps from all ones to 0, aux_clk toggles. Period is 2**(AUX_BIT+1) cycles.
- Reset asserted mid-period: all state returns immediately to reset values. The first half-period after release uses the slowest preset.
- Outputs are glitch-free registers. No combinational path exists from inputs to out_clk or aux_clk.

Decomposition:
- Package freq_gen_pkg holds:
  - the default constants CNT_W, SEL_W, BASE_DIV and AUX_BIT;
  - the preset-divisor function (shift with saturation) as a constant function.
- One sub-module, free_prescaler:
  - parametrised by AUX_BIT;
  - ports clk, rst, toggle out;
  - instantiated for aux_clk.
- Divider counter, divisor shadow register and strobe stay in the top module.

Test Plan:
All tests use CNT_W=8, SEL_W=2, BASE_DIV=4, AUX_BIT=3.
- Reset then en=1, freq=3, div_mode=0 -> first toggle at cycle 32 (reset preset 32). After that out_clk toggles every 4 cycles, with out_tick a single-cycle pulse at each toggle and div_active=4.
- Running at freq=3, switch to freq=1 mid half-period (cnt=1) -> current half-period still ends after 4 cycles, the next lasts 16, and no out_clk level is shorter than 4.
- div_mode=1, div_custom=0, then 1, then 5 -> 0 behaves as 1 (toggle every cycle, out_tick stuck high). 5 gives levels of exactly 5 cycles.
- en deasserted for 7 cycles at cnt=2 with div 4 -> cnt and out_clk frozen and out_tick low. After re-enable, the toggle occurs 2 cycles later.
- sync_clr pulse while out_clk=1 -> next cycle out_clk=0 and cnt=0, with the new divisor loaded. aux_clk phase is unaffected and still toggles every 8 cycles.
- BASE_DIV=100, freq=0 (100<<3 = 800 > 255) -> div_active saturates to 255. Assert rst mid-period -> outputs clear asynchronously, before the next clk edge.

Source files
------------

// File: rtl/freq_gen_pkg.sv
// Shared defaults and preset-divisor helper for the programmable clock divider.
// The preset table is BASE_DIV scaled by powers of two, clipped to the counter width.
package freq_gen_pkg;

    localparam int CNT_W    = 16;
    localparam int SEL_W    = 2;
    localparam int BASE_DIV = 400;
    localparam int AUX_BIT  = 11;

    // Code 0 is the slowest preset and the all-ones code is BASE_DIV itself.
    // The result saturates to the largest value that fits in cnt_w bits.
    function automatic logic [63:0] preset_div(input logic [63:0] base,
                                               input int unsigned sel,
                                               input int unsigned sel_w,
                                               input int unsigned cnt_w);
        int unsigned sh;
        logic [63:0] max_v;
        logic [63:0] val;
        sh    = (32'd1 << sel_w) - 32'd1 - sel;
        max_v = (cnt_w >= 32'd64) ? '1 : ((64'd1 << cnt_w) - 64'd1);
        val   = base << sh;
        if (((val >> sh) != base) || (val > max_v))
            val = max_v;
        return val;
    endfunction

endpackage

// File: rtl/free_prescaler.sv
// Free-running AUX_BIT-bit prescaler; its output flips each time the count wraps.
// Only reset touches it, so it stays phase-stable across divider enables and restarts.
module free_prescaler #(
    parameter int AUX_BIT = 11
) (
    input  logic clk,
    input  logic rst,
    output logic toggle
);

    logic [AUX_BIT-1:0] pre_q, pre_d;
    logic               tgl_q, tgl_d;

    always_comb begin
        pre_d = pre_q + AUX_BIT'(1);
        tgl_d = (&pre_q) ? ~tgl_q : tgl_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            tgl_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            tgl_q <= tgl_d;
        end
    end

    assign toggle = tgl_q;

endmodule

// File: rtl/freq_divider_gen.sv
// Programmable 50%-duty clock divider with glitch-free divisor switching,
// enable, phase restart, toggle strobe and an independent auxiliary slow clock.
module freq_divider_gen #(
    parameter int CNT_W    = freq_gen_pkg::CNT_W,
    parameter int SEL_W    = freq_gen_pkg::SEL_W,
    parameter int BASE_DIV = freq_gen_pkg::BASE_DIV,
    parameter int AUX_BIT  = freq_gen_pkg::AUX_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] freq,
    input  logic             div_mode,
    input  logic [CNT_W-1:0] div_custom,
    input  logic             sync_clr,
    output logic             out_clk,
    output logic             out_tick,
    output logic             aux_clk,
    output logic [CNT_W-1:0] div_active
);

    import freq_gen_pkg::*;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] SLOW_RAW =
        CNT_W'(preset_div(64'(BASE_DIV), 32'd0, 32'(SEL_W), 32'(CNT_W)));
    localparam logic [CNT_W-1:0] DIV_SLOW = (SLOW_RAW == '0) ? ONE : SLOW_RAW;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic             out_clk_q, out_clk_d;
    logic             out_tick_q, out_tick_d;
    logic [CNT_W-1:0] div_sel, div_req;

    always_comb begin
        div_sel = div_mode ? div_custom
                           : CNT_W'(preset_div(64'(BASE_DIV), 32'(freq), 32'(SEL_W), 32'(CNT_W)));
        div_req = (div_sel == '0) ? ONE : div_sel;
    end

    // The divisor is only re-sampled at a half-period boundary or a restart, so a
    // level already in progress always completes with the length it started with.
    // Using >= on the boundary compare also recovers from an out-of-range count.
    always_comb begin
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        out_clk_d    = out_clk_q;
        out_tick_d   = 1'b0;
        if (sync_clr) begin
            cnt_d        = '0;
            out_clk_d    = 1'b0;
            div_active_d = div_req;
        end else if (en) begin
            if (cnt_q >= div_active_q - ONE) begin
                cnt_d        = '0;
                out_clk_d    = ~out_clk_q;
                out_tick_d   = 1'b1;
                div_active_d = div_req;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            div_active_q <= DIV_SLOW;
            out_clk_q    <= 1'b0;
            out_tick_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            out_clk_q    <= out_clk_d;
            out_tick_q   <= out_tick_d;
        end
    end

    free_prescaler #(.AUX_BIT(AUX_BIT)) u_aux (
        .clk    (clk),
        .rst    (rst),
        .toggle (aux_clk)
    );

    assign out_clk    = out_clk_q;
    assign out_tick   = out_tick_q;
    assign div_active = div_active_q;

endmodule
